// File: rtl/cb_tmr_pkg.sv
// Shared types for the triple-modular-redundant data-port voter:
// OBI request/response bundles, FSM states, captured requests and vote results.
package cb_tmr_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic              gnt;
        logic              rvalid;
        logic [DATA_W-1:0] rdata;
    } obi_resp_t;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_R,
        RESP
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } cap_req_t;

    typedef struct packed {
        cap_req_t   fields;
        logic [2:0] outlier_mask;
        logic       valid;
    } vote_t;

    // Write data is meaningless on a read, so it is zeroed before comparing.
    function automatic cap_req_t norm_req(input cap_req_t c);
        cap_req_t r;
        r = c;
        if (!c.we) begin
            r.wdata = '0;
        end
        return r;
    endfunction

endpackage

// File: rtl/tmr_data_voter_if.sv
// Bundle of the voter's core-side, bus-side and status signals.
// master: the cores and system bus around the voter; slave: the voter itself.
interface tmr_data_voter_if;
    import cb_tmr_pkg::*;

    obi_req_t   core_req  [3];
    obi_resp_t  core_resp [3];
    obi_req_t   bus_req;
    obi_resp_t  bus_resp;
    logic       mismatch;
    logic [2:0] mismatch_mask;
    logic       fatal;

    modport master (
        output core_req, bus_resp,
        input  core_resp, bus_req, mismatch, mismatch_mask, fatal
    );

    modport slave (
        input  core_req, bus_resp,
        output core_resp, bus_req, mismatch, mismatch_mask, fatal
    );

endinterface

// File: rtl/tmr_majority.sv
// Combinational 2-of-3 vote over the captured requests of three harts.
// Uncaptured harts are zeroed so they never form a pair with anyone.
import cb_tmr_pkg::*;

module tmr_majority (
    input  cap_req_t   cap [3],
    input  logic [2:0] captured,
    output vote_t      vote
);

    cap_req_t n [3];
    cap_req_t maj;
    logic     eq01;
    logic     eq02;
    logic     eq12;

    // Bitwise majority plus pairwise agreement decides the vote and the outliers.
    always_comb begin
        vote = '0;
        for (int i = 0; i < 3; i++) begin
            n[i] = captured[i] ? norm_req(cap[i]) : '0;
        end
        maj  = (n[0] & n[1]) | (n[0] & n[2]) | (n[1] & n[2]);
        eq01 = captured[0] && captured[1] && (n[0] == n[1]);
        eq02 = captured[0] && captured[2] && (n[0] == n[2]);
        eq12 = captured[1] && captured[2] && (n[1] == n[2]);
        vote.valid  = eq01 || eq02 || eq12;
        vote.fields = vote.valid ? maj : '0;
        for (int i = 0; i < 3; i++) begin
            vote.outlier_mask[i] = !(vote.valid && captured[i] && (n[i] == maj));
        end
    end

endmodule

// File: rtl/tmr_data_voter.sv
// Collects one data request from each of three lockstep harts, votes them,
// issues a single bus transaction and fans the response back out.
import cb_tmr_pkg::*;

module tmr_data_voter #(
    parameter int TIMEOUT_CYCLES = 8,
    parameter int NHARTS         = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  obi_req_t          core_data_req_i  [NHARTS],
    output obi_resp_t         core_data_resp_o [NHARTS],
    output obi_req_t          bus_req_o,
    input  obi_resp_t         bus_resp_i,
    output logic              mismatch_o,
    output logic [NHARTS-1:0] mismatch_mask_o,
    output logic              fatal_o
);

    if (NHARTS != 3) begin : g_nharts_check
        $error("tmr_data_voter supports exactly three harts");
    end

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e            state;
    state_e            next_state;
    logic [NHARTS-1:0] captured;
    logic [NHARTS-1:0] gnt;
    logic [NHARTS-1:0] cap_all;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rdata_q;
    cap_req_t          cap_q [NHARTS];
    vote_t             vote;

    tmr_majority u_majority (
        .cap      (cap_q),
        .captured (captured),
        .vote     (vote)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Grants, next state and all handshake outputs.
    always_comb begin
        next_state = state;
        bus_req_o  = '0;
        gnt        = '0;
        for (int i = 0; i < NHARTS; i++) begin
            gnt[i] = !rst_i && (state == IDLE || state == COLLECT) &&
                     core_data_req_i[i].req && !captured[i];
        end
        cap_all = captured | gnt;
        for (int i = 0; i < NHARTS; i++) begin
            core_data_resp_o[i]        = '0;
            core_data_resp_o[i].gnt    = gnt[i];
            core_data_resp_o[i].rvalid = (state == RESP) && captured[i];
            core_data_resp_o[i].rdata  = (state == RESP) ? rdata_q : '0;
        end
        case (state)
            IDLE: begin
                if (|gnt) begin
                    next_state = (&cap_all) ? ISSUE : COLLECT;
                end
            end
            COLLECT: begin
                if ((&cap_all) || (count == CNT_W'(TIMEOUT_CYCLES - 1))) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (!vote.valid) begin
                    next_state = RESP;
                end else begin
                    bus_req_o.req   = 1'b1;
                    bus_req_o.addr  = vote.fields.addr;
                    bus_req_o.we    = vote.fields.we;
                    bus_req_o.be    = vote.fields.be;
                    bus_req_o.wdata = vote.fields.wdata;
                    if (bus_resp_i.gnt) begin
                        next_state = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (bus_resp_i.rvalid) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request fields are latched on their grant; gated by state, so no reset needed.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NHARTS; i++) begin
            if (gnt[i]) begin
                cap_q[i] <= '{addr:  core_data_req_i[i].addr,
                              we:    core_data_req_i[i].we,
                              be:    core_data_req_i[i].be,
                              wdata: core_data_req_i[i].wdata};
            end
        end
    end

    // Capture mask, timeout counter, read data and error reporting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            captured        <= '0;
            count           <= '0;
            rdata_q         <= '0;
            mismatch_o      <= 1'b0;
            mismatch_mask_o <= '0;
            fatal_o         <= 1'b0;
        end else begin
            mismatch_o <= 1'b0;
            case (state)
                IDLE: begin
                    captured <= cap_all;
                    count    <= '0;
                end
                COLLECT: begin
                    captured <= cap_all;
                    count    <= count + 1'b1;
                end
                RESP:    captured <= '0;
                default: ;
            endcase
            if (state == ISSUE && !vote.valid) begin
                rdata_q <= '0;
                fatal_o <= 1'b1;
            end
            if (state == WAIT_R && bus_resp_i.rvalid) begin
                rdata_q <= bus_resp_i.rdata;
            end
            if (next_state == RESP && state != RESP && (|vote.outlier_mask)) begin
                mismatch_o      <= 1'b1;
                mismatch_mask_o <= vote.outlier_mask;
            end
        end
    end

endmodule

// File: tb/tb_tmr_data_voter.sv
// Self-checking bench for tmr_data_voter: directed scenarios plus randomized
// transactions compared against a behavioural vote model.
module tb_tmr_data_voter;
    import cb_tmr_pkg::*;

    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         n_chk = 0;
    int         n_fail = 0;
    int         mm_seen = 0;
    logic       fatal_exp = 1'b0;
    logic [2:0] mask_exp = 3'b000;

    tmr_data_voter_if vif ();

    tmr_data_voter #(
        .TIMEOUT_CYCLES (TMO),
        .NHARTS         (3)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_data_req_i  (vif.core_req),
        .core_data_resp_o (vif.core_resp),
        .bus_req_o        (vif.bus_req),
        .bus_resp_i       (vif.bus_resp),
        .mismatch_o       (vif.mismatch),
        .mismatch_mask_o  (vif.mismatch_mask),
        .fatal_o          (vif.fatal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; everything is sampled/driven 1 time unit after the rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
        if (vif.mismatch) mm_seen++;
    endtask

    function automatic logic [2:0] gnt_vec();
        return {vif.core_resp[2].gnt, vif.core_resp[1].gnt, vif.core_resp[0].gnt};
    endfunction

    function automatic logic [2:0] rv_vec();
        return {vif.core_resp[2].rvalid, vif.core_resp[1].rvalid, vif.core_resp[0].rvalid};
    endfunction

    // Reference vote: find any two present harts with identical {addr,we,be,wdata-if-write}.
    function automatic void vote_model(input logic [2:0] pres, input obi_req_t r [3],
                                       output logic ok, output logic [68:0] win,
                                       output logic [2:0] mask);
        logic [68:0] key [3];
        ok  = 1'b0;
        win = '0;
        for (int i = 0; i < 3; i++) begin
            key[i] = {r[i].addr, r[i].we, r[i].be, (r[i].we ? r[i].wdata : 32'h0)};
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 3; j++) begin
                if (pres[i] && pres[j] && key[i] == key[j]) begin
                    ok  = 1'b1;
                    win = key[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            mask[i] = !(ok && pres[i] && key[i] == win);
        end
    endfunction

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"}, gnt_vec(), 3'b000);
        chk({tag, "_rvalid"}, rv_vec(), 3'b000);
        chk({tag, "_rdata"}, vif.core_resp[0].rdata | vif.core_resp[1].rdata | vif.core_resp[2].rdata, 0);
        chk({tag, "_bus_req"}, vif.bus_req, 0);
        chk({tag, "_status"}, {vif.mismatch, vif.mismatch_mask, vif.fatal}, 0);
    endtask

    task automatic run_txn(input string tag, input logic [2:0] pres, input obi_req_t r [3],
                           input int gd, input int rd, input logic [31:0] rdat);
        logic        ok;
        logic [68:0] win;
        logic [2:0]  mask;
        logic        flag;
        int          t;
        int          exp_issue;
        logic [31:0] exp_rdata;
        vote_model(pres, r, ok, win, mask);
        flag      = |mask;
        exp_issue = (&pres) ? 1 : 1 + TMO;
        exp_rdata = ok ? rdat : 32'h0;
        mm_seen   = 0;
        nxt();
        for (int i = 0; i < 3; i++) begin
            vif.core_req[i]     = r[i];
            vif.core_req[i].req = pres[i];
        end
        #1;
        chk({tag, "_gnt"}, gnt_vec(), pres);
        nxt();
        for (int i = 0; i < 3; i++) vif.core_req[i] = '0;
        t = 1;
        while (!vif.bus_req.req && rv_vec() == 3'b000 && t < 40) begin
            nxt();
            t++;
        end
        if (ok) begin
            chk({tag, "_issue_lat"}, t, exp_issue);
            chk({tag, "_bus_fields"}, {vif.bus_req.req, vif.bus_req.addr, vif.bus_req.we,
                                       vif.bus_req.be, vif.bus_req.wdata}, {1'b1, win});
            for (int k = 0; k < gd; k++) begin
                nxt();
                chk({tag, "_req_hold"}, {vif.bus_req.req, vif.bus_req.addr, vif.bus_req.we,
                                         vif.bus_req.be, vif.bus_req.wdata}, {1'b1, win});
            end
            vif.bus_resp.gnt = 1'b1;
            nxt();
            vif.bus_resp.gnt = 1'b0;
            chk({tag, "_req_dropped"}, vif.bus_req.req, 1'b0);
            for (int k = 0; k < rd; k++) nxt();
            vif.bus_resp.rvalid = 1'b1;
            vif.bus_resp.rdata  = rdat;
            nxt();
            vif.bus_resp.rvalid = 1'b0;
            vif.bus_resp.rdata  = '0;
        end else begin
            chk({tag, "_resp_lat_nobus"}, t, exp_issue + 1);
            chk({tag, "_no_bus_req"}, vif.bus_req.req, 1'b0);
            fatal_exp = 1'b1;
        end
        if (flag) mask_exp = mask;
        chk({tag, "_rvalid"}, rv_vec(), pres);
        for (int i = 0; i < 3; i++) begin
            if (pres[i]) chk({tag, "_rdata"}, vif.core_resp[i].rdata, exp_rdata);
        end
        chk({tag, "_mismatch"}, vif.mismatch, flag);
        chk({tag, "_mask"}, vif.mismatch_mask, mask_exp);
        chk({tag, "_fatal"}, vif.fatal, fatal_exp);
        nxt();
        chk({tag, "_mm_pulses"}, mm_seen, flag ? 1 : 0);
        chk({tag, "_rvalid_end"}, rv_vec(), 3'b000);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        obi_req_t    r [3];
        obi_req_t    base;
        logic [2:0]  pres;
        int          kind;
        int          h;
        int          h2;

        for (int i = 0; i < 3; i++) begin
            vif.core_req[i]     = '0;
            vif.core_req[i].req = 1'b1;
        end
        vif.bus_resp = '{gnt: 1'b1, rvalid: 1'b1, rdata: 32'hFFFF_FFFF};
        #12;
        chk_outputs_zero("reset");
        for (int i = 0; i < 3; i++) vif.core_req[i] = '0;
        vif.bus_resp = '0;
        nxt();
        rst = 1'b0;

        // Lockstep write.
        base = '{req: 1'b1, addr: 32'h2000_0010, we: 1'b1, be: 4'hF, wdata: 32'hA5A5_A5A5};
        r = '{base, base, base};
        run_txn("lockstep_wr", 3'b111, r, 0, 0, 32'h0);

        // Single upset on hart 1's address.
        base = '{req: 1'b1, addr: 32'h2000_0010, we: 1'b0, be: 4'hF, wdata: 32'h0};
        r = '{base, base, base};
        r[1].addr = 32'h2000_0014;
        run_txn("upset_h1", 3'b111, r, 1, 2, 32'h1234_5678);

        // Hart 2 never shows up.
        r = '{base, base, base};
        run_txn("timeout_h2", 3'b011, r, 0, 1, 32'hCAFE_F00D);

        // Reads differing only in wdata still agree.
        r = '{base, base, base};
        r[0].wdata = 32'hDEAD_0001;
        r[2].wdata = 32'hDEAD_0002;
        run_txn("read_wdata_ignored", 3'b111, r, 0, 0, 32'h0BAD_CAFE);

        for (int n = 0; n < 40; n++) begin
            base = '{req: 1'b1, addr: $urandom & 32'hFFFF_FFFC, we: 1'($urandom_range(0, 1)),
                     be: 4'($urandom_range(1, 15)), wdata: $urandom};
            r    = '{base, base, base};
            pres = 3'b111;
            kind = $urandom_range(0, 9);
            h    = $urandom_range(0, 2);
            h2   = (h + 1) % 3;
            case (kind)
                4: r[h].addr  = r[h].addr ^ (32'h1 << $urandom_range(2, 31));
                5: r[h].wdata = ~r[h].wdata;
                6: r[h].be    = ~r[h].be;
                7: pres[h]    = 1'b0;
                8: pres       = 3'b111 & ~((3'b001 << h) | (3'b001 << h2));
                9: begin
                    r[h].addr  = r[h].addr ^ 32'h4;
                    r[h2].addr = r[h2].addr ^ 32'h8;
                end
                default: ;
            endcase
            run_txn("random", pres, r, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        // No majority at all.
        r = '{base, base, base};
        r[0].addr = 32'h3000_0000;
        r[1].addr = 32'h3000_0100;
        r[2].addr = 32'h3000_0200;
        run_txn("no_majority", 3'b111, r, 0, 0, 32'h5555_AAAA);

        // Reset while waiting for the bus read data.
        base = '{req: 1'b1, addr: 32'h2000_0020, we: 1'b0, be: 4'hF, wdata: 32'h0};
        nxt();
        for (int i = 0; i < 3; i++) vif.core_req[i] = base;
        nxt();
        for (int i = 0; i < 3; i++) vif.core_req[i] = '0;
        chk("rst_wait_issue", vif.bus_req.req, 1'b1);
        vif.bus_resp.gnt = 1'b1;
        nxt();
        vif.bus_resp.gnt = 1'b0;
        for (int i = 0; i < 3; i++) vif.core_req[i] = base;
        rst = 1'b1;
        #1;
        chk_outputs_zero("in_reset");
        nxt();
        chk_outputs_zero("in_reset_clk");
        for (int i = 0; i < 3; i++) vif.core_req[i] = '0;
        rst       = 1'b0;
        fatal_exp = 1'b0;
        mask_exp  = 3'b000;
        vif.bus_resp.rvalid = 1'b1;
        vif.bus_resp.rdata  = 32'hDEAD_BEEF;
        nxt();
        vif.bus_resp.rvalid = 1'b0;
        vif.bus_resp.rdata  = '0;
        chk("late_rvalid_ignored", {rv_vec(), vif.bus_req.req}, 4'b0000);
        r = '{base, base, base};
        run_txn("after_reset", 3'b111, r, 0, 0, 32'h7777_1111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
